// File: rtl/fifo_stream_par_if.sv
// Stream link bundle for fifo_stream_par: producer side, consumer side, flush and status.
// The slave modport is the FIFO; the master modport is whatever drives it.
interface fifo_stream_par_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic             clear;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [AW:0]      count;
  logic             almost_full;
  logic             almost_empty;

  modport master (
    output clear, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count, almost_full, almost_empty
  );

  modport slave (
    input  clear, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count, almost_full, almost_empty
  );
endinterface

// File: rtl/fifo_stream_par.sv
// Synchronous valid/ready FIFO for dataflow actor links with occupancy count,
// almost-full/almost-empty flags, synchronous flush and selectable FWFT read mode.
module fifo_stream_par #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 1
) (
  input logic              ck,
  input logic              reset,
  fifo_stream_par_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             empty, full, push, pop;
  logic [AW-1:0]    rd_addr, wr_addr;

  assign rd_addr = rd_ptr_q[AW-1:0];
  assign wr_addr = wr_ptr_q[AW-1:0];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_addr == rd_addr);
  // in_ready comes from registered pointers only, so out_ready never reaches it
  assign push    = bus.in_valid & ~full;
  assign pop     = bus.out_ready & ~empty;

  assign bus.in_ready     = ~full;
  assign bus.count        = count_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    af_d     = af_q;
    ae_d     = ae_q;
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      af_d     = 1'b0;
      ae_d     = 1'b1;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      af_d = (int'(count_d) >= AF_LEVEL);
      ae_d = (int'(count_d) <= AE_LEVEL);
    end
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  // Storage is not reset; a flush drops the concurrent word
  always_ff @(posedge ck) begin
    if (push && !bus.clear) mem_q[wr_addr] <= bus.in_data;
  end

  if (FWFT != 0) begin : g_fwft
    // Empty FIFO presents zero so the output is defined out of reset
    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? '0 : mem_q[rd_addr];
  end else begin : g_strobe
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovld_q, ovld_d;

    always_comb begin
      dout_d = dout_q;
      ovld_d = 1'b0;
      if (pop && !bus.clear) begin
        dout_d = mem_q[rd_addr];
        ovld_d = 1'b1;
      end
    end

    always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
        dout_q <= '0;
        ovld_q <= 1'b0;
      end else begin
        dout_q <= dout_d;
        ovld_q <= ovld_d;
      end
    end

    assign bus.out_valid = ovld_q;
    assign bus.out_data  = dout_q;
  end
endmodule

// File: tb/tb_fifo_stream_par.sv
// Directed bench: FWFT instance for fill/drain/steady/flush/reset, strobe-mode instance for reads.
module tb_fifo_stream_par;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic ck = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 ck = ~ck;

  fifo_stream_par_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_a ();
  fifo_stream_par_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_b ();

  fifo_stream_par #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut_a (
    .ck(ck), .reset(reset), .bus(bus_a)
  );
  fifo_stream_par #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut_b (
    .ck(ck), .reset(reset), .bus(bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus_a.clear = 0; bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.out_ready = 0;
    bus_b.clear = 0; bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.out_ready = 0;
    #2;
    check("rst_in_ready", bus_a.in_ready, 1);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_out_data", bus_a.out_data, 0);
    check("rst_count", bus_a.count, 0);
    check("rst_af", bus_a.almost_full, 0);
    check("rst_ae", bus_a.almost_empty, 1);
    check("rst_b_out_valid", bus_b.out_valid, 0);
    check("rst_b_out_data", bus_b.out_data, 0);
    tick();
    reset = 1'b0;
    tick();

    // Fill 0x01..0x08, then 0x09 stays pending
    bus_a.in_valid = 1;
    for (int k = 1; k <= 8; k++) begin
      bus_a.in_data = 8'(k);
      tick();
      check("fill_count", bus_a.count, k);
      check("fill_af", bus_a.almost_full, (k >= 6) ? 1 : 0);
      check("fill_ae", bus_a.almost_empty, (k <= 2) ? 1 : 0);
      check("fill_in_ready", bus_a.in_ready, (k == 8) ? 0 : 1);
      check("fill_head", bus_a.out_data, 8'h01);
    end
    bus_a.in_data = 8'h09;
    tick();
    check("full_hold_count", bus_a.count, 8);
    check("full_hold_in_ready", bus_a.in_ready, 0);
    bus_a.in_valid = 0;

    // Drain from full
    bus_a.out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      check("drain_valid", bus_a.out_valid, 1);
      check("drain_data", bus_a.out_data, k);
      tick();
      check("drain_count", bus_a.count, 8 - k);
    end
    check("drain_empty_valid", bus_a.out_valid, 0);
    check("drain_empty_ae", bus_a.almost_empty, 1);
    bus_a.out_ready = 0;

    // Steady state at count=4 across pointer wraps
    bus_a.in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      bus_a.in_data = 8'(8'hA0 + k);
      tick();
    end
    check("steady_pre_count", bus_a.count, 4);
    bus_a.out_ready = 1;
    for (int k = 0; k < 20; k++) begin
      bus_a.in_data = 8'(8'hA4 + k);
      check("steady_data", bus_a.out_data, 8'(8'hA0 + k));
      tick();
      check("steady_count", bus_a.count, 4);
    end
    bus_a.out_ready = 0;
    check("steady_head", bus_a.out_data, 8'hB4);

    // Flush at count=5 with concurrent push and pop
    bus_a.in_data = 8'hC0;
    tick();
    check("pre_clear_count", bus_a.count, 5);
    bus_a.clear = 1; bus_a.in_data = 8'hEE; bus_a.out_ready = 1;
    tick();
    bus_a.clear = 0; bus_a.in_valid = 0; bus_a.out_ready = 0;
    check("clear_count", bus_a.count, 0);
    check("clear_in_ready", bus_a.in_ready, 1);
    check("clear_out_valid", bus_a.out_valid, 0);
    check("clear_ae", bus_a.almost_empty, 1);
    check("clear_af", bus_a.almost_full, 0);
    tick();
    check("clear_dropped_count", bus_a.count, 0);
    check("clear_dropped_valid", bus_a.out_valid, 0);

    // Strobe-mode reads
    bus_b.in_valid = 1;
    bus_b.in_data = 8'h11; tick();
    bus_b.in_data = 8'h22; tick();
    bus_b.in_data = 8'h33; tick();
    bus_b.in_valid = 0;
    check("b_count3", bus_b.count, 3);
    check("b_idle_valid", bus_b.out_valid, 0);
    bus_b.out_ready = 1;
    tick();
    bus_b.out_ready = 0;
    check("b_pop_valid", bus_b.out_valid, 1);
    check("b_pop_data", bus_b.out_data, 8'h11);
    check("b_pop_count", bus_b.count, 2);
    tick();
    check("b_pulse_valid", bus_b.out_valid, 0);
    check("b_hold_data", bus_b.out_data, 8'h11);
    bus_b.out_ready = 1;
    tick();
    check("b_pop2_data", bus_b.out_data, 8'h22);
    tick();
    check("b_pop3_data", bus_b.out_data, 8'h33);
    check("b_pop3_count", bus_b.count, 0);
    tick();
    check("b_empty_valid", bus_b.out_valid, 0);
    check("b_empty_data", bus_b.out_data, 8'h33);
    check("b_empty_count", bus_b.count, 0);
    bus_b.out_ready = 0;

    // Asynchronous reset mid-burst
    bus_a.in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      bus_a.in_data = 8'(8'h40 + k);
      tick();
    end
    check("burst_count", bus_a.count, 3);
    #1 reset = 1'b1;
    #1;
    check("areset_count", bus_a.count, 0);
    check("areset_in_ready", bus_a.in_ready, 1);
    check("areset_out_valid", bus_a.out_valid, 0);
    check("areset_out_data", bus_a.out_data, 0);
    check("areset_af", bus_a.almost_full, 0);
    check("areset_ae", bus_a.almost_empty, 1);
    #1 reset = 1'b0;
    bus_a.in_data = 8'h55;
    tick();
    bus_a.in_data = 8'h66;
    tick();
    bus_a.in_valid = 0;
    check("refill_count", bus_a.count, 2);
    check("refill_head", bus_a.out_data, 8'h55);
    bus_a.out_ready = 1;
    tick();
    bus_a.out_ready = 0;
    check("refill_next", bus_a.out_data, 8'h66);
    check("refill_count1", bus_a.count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
